music_sheet_player: RTL and testbench

MUSIC_SHEET_PLAYER -- requirements
Module: music_sheet_player

---
 rtl/music_sheet_player_pkg.sv | 38 +++
 rtl/music_sheet_player_if.sv | 26 ++
 rtl/music_sheet_player_beat_down_counter.sv | 33 +++
 rtl/music_sheet_player.sv | 112 +++++++++++
 tb/tb_music_sheet_player.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/music_sheet_player_pkg.sv
// Shared types and constants for the music sheet player.
package music_sheet_player_pkg;

    localparam int unsigned DATA_W   = 9;
    localparam int unsigned NOTE_W   = 5;
    localparam int unsigned DUR_W    = 4;
    localparam int unsigned CNT_W    = 5;

    // Field positions inside a sheet entry
    localparam int unsigned NOTE_MSB = 8;
    localparam int unsigned NOTE_LSB = 4;
    localparam int unsigned DUR_MSB  = 3;
    localparam int unsigned DUR_LSB  = 0;

    localparam logic [NOTE_W-1:0] END_CODE_DEF = 5'd31;
    localparam logic [NOTE_W-1:0] REST_CODE    = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_PLAY
    } state_t;

    function automatic logic [NOTE_W-1:0] note_of(input logic [DATA_W-1:0] d);
        return d[NOTE_MSB:NOTE_LSB];
    endfunction

    function automatic logic [DUR_W-1:0] dur_of(input logic [DATA_W-1:0] d);
        return d[DUR_MSB:DUR_LSB];
    endfunction

    // A zero duration field encodes the longest note, 16 beats
    function automatic logic [CNT_W-1:0] beats_of(input logic [DUR_W-1:0] dur);
        return (dur == '0) ? CNT_W'(16) : CNT_W'(dur);
    endfunction

endpackage

// File: rtl/music_sheet_player_if.sv
// Control, tempo and sheet-memory signals of the music sheet player.
interface music_sheet_player_if #(
    parameter int unsigned ADDR_W = 5
) ();

    logic                                      play;
    logic                                      stop;
    logic                                      beat_tick;
    logic [ADDR_W-1:0]                         read_address;
    logic [music_sheet_player_pkg::DATA_W-1:0] read_data;
    logic [music_sheet_player_pkg::NOTE_W-1:0] note;
    logic                                      note_valid;
    logic                                      playing;
    logic                                      done;

    modport master (
        output play, stop, beat_tick, read_data,
        input  read_address, note, note_valid, playing, done
    );

    modport slave (
        input  play, stop, beat_tick, read_data,
        output read_address, note, note_valid, playing, done
    );

endinterface

// File: rtl/music_sheet_player_beat_down_counter.sv
// Beat counter: loads a note duration, counts beat ticks down to zero.
module beat_down_counter
    import music_sheet_player_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [DUR_W-1:0] load_val,
    input  logic             tick,
    output logic             zero_c,
    output logic             one_c
);

    logic [CNT_W-1:0] count;

    // Clear beats load, load beats tick; never wraps below zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= beats_of(load_val);
        end else if (tick && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero_c = (count == '0);
    assign one_c  = (count == CNT_W'(1));

endmodule

// File: rtl/music_sheet_player.sv
// Music sheet player: walks a sheet memory and sounds each entry for its
// duration in beats. Define LOOP_EN to restart the sheet at its end instead
// of stopping with a Done pulse.
module music_sheet_player
    import music_sheet_player_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 5,
    parameter logic [NOTE_W-1:0] END_CODE = END_CODE_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    music_sheet_player_if.slave   bus
);

    state_t            state;
    logic [NOTE_W-1:0] rd_note;
    logic [DUR_W-1:0]  rd_dur;
    logic              cnt_load;
    logic              cnt_tick;
    logic              cnt_zero_c;
    logic              cnt_one_c;
    logic              note_end_c;
    logic              last_addr_c;
    logic              end_hit_c;

    assign rd_note     = note_of(bus.read_data);
    assign rd_dur      = dur_of(bus.read_data);
    assign cnt_load    = (state == ST_LOAD) && (rd_note != END_CODE);
    assign cnt_tick    = (state == ST_PLAY) && bus.beat_tick;
    // Zero term keeps a cleared counter from trapping the FSM in PLAY
    assign note_end_c  = cnt_tick && (cnt_one_c || cnt_zero_c);
    assign last_addr_c = (bus.read_address == {ADDR_W{1'b1}});
    assign end_hit_c   = ((state == ST_LOAD) && (rd_note == END_CODE)) ||
                         (note_end_c && last_addr_c);

    beat_down_counter u_beat_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (bus.stop),
        .load     (cnt_load),
        .load_val (rd_dur),
        .tick     (cnt_tick),
        .zero_c   (cnt_zero_c),
        .one_c    (cnt_one_c)
    );

    // Playback FSM with registered outputs; Stop outranks everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            bus.read_address <= '0;
            bus.note         <= REST_CODE;
            bus.note_valid   <= 1'b0;
            bus.playing      <= 1'b0;
            bus.done         <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (bus.stop) begin
                state            <= ST_IDLE;
                bus.read_address <= '0;
                bus.note         <= REST_CODE;
                bus.note_valid   <= 1'b0;
                bus.playing      <= 1'b0;
            end else if (end_hit_c) begin
`ifdef LOOP_EN
                state            <= ST_FETCH;
                bus.read_address <= '0;
                bus.note         <= REST_CODE;
                bus.note_valid   <= 1'b0;
                bus.playing      <= 1'b1;
`else
                state            <= ST_IDLE;
                bus.read_address <= '0;
                bus.note         <= REST_CODE;
                bus.note_valid   <= 1'b0;
                bus.playing      <= 1'b0;
                bus.done         <= 1'b1;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.play) begin
                            state            <= ST_FETCH;
                            bus.read_address <= '0;
                            bus.playing      <= 1'b1;
                        end
                    end
                    ST_FETCH: begin
                        state <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        state          <= ST_PLAY;
                        bus.note       <= rd_note;
                        bus.note_valid <= 1'b1;
                    end
                    ST_PLAY: begin
                        if (note_end_c) begin
                            state            <= ST_FETCH;
                            bus.read_address <= bus.read_address + ADDR_W'(1);
                            bus.note         <= REST_CODE;
                            bus.note_valid   <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_music_sheet_player.sv
// Self-checking bench for music_sheet_player: note scoreboard plus
// hand-written sequences for stop, reset and wrap corner cases.
module tb_music_sheet_player;
    import music_sheet_player_pkg::*;

    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 1 << AW;

    typedef struct {
        int note;
        int addr;
        int beats;
        int gap;     // expected silent cycles before this note, -1 = unchecked
    } exp_t;

    typedef struct {
        logic [4:0] code;
        logic [3:0] dur;
        int         beats;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    music_sheet_player_if #(.ADDR_W(AW)) bus ();

    music_sheet_player #(.ADDR_W(AW), .END_CODE(5'd31)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Sheet memory with one cycle of read latency
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) bus.read_data <= mem[bus.read_address];

    int n_vec = 0;
    int n_err = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Tempo divider stand-in
    bit tick_en     = 1'b0;
    int tick_period = 10;
    int tick_cnt    = 0;
    initial begin
        bus.beat_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_en) begin
                tick_cnt++;
                bus.beat_tick = ((tick_cnt % tick_period) == 0);
            end else begin
                tick_cnt      = 0;
                bus.beat_tick = 1'b0;
            end
        end
    end

    // Scoreboard monitor: note starts, beat counts, inter-note gaps, Done pulses
    exp_t exp_q[$];
    exp_t cur;
    int   done_cnt  = 0;
    int   cur_beats = 0;
    int   gap_cnt   = 0;
    bit   prev_nv, prev_stop, prev_rst, gap_armed, in_note;
    always @(negedge clk) begin
        bit abort;
        abort = prev_stop || prev_rst || rst;
        if (bus.done) done_cnt++;
        if (bus.note_valid && !prev_nv) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected_note: got note %0d at addr %0d, expected none",
                         bus.note, bus.read_address);
            end else begin
                cur = exp_q.pop_front();
                check("note_code", int'(bus.note), cur.note);
                check("note_addr", int'(bus.read_address), cur.addr);
                if (cur.gap >= 0) check("note_gap", gap_armed ? gap_cnt : -1, cur.gap);
                in_note = 1'b1;
            end
            cur_beats = 0;
            gap_armed = 1'b0;
        end else if (!bus.note_valid && prev_nv) begin
            if (in_note && !abort) check("note_beats", cur_beats, cur.beats);
            in_note   = 1'b0;
            gap_armed = bus.playing && !abort;
            gap_cnt   = 1;
        end else if (!bus.note_valid && gap_armed) begin
            if (bus.playing && !abort) gap_cnt++;
            else gap_armed = 1'b0;
        end
        if (bus.note_valid && bus.beat_tick) cur_beats++;
        prev_nv   = bus.note_valid;
        prev_stop = bus.stop;
        prev_rst  = rst;
    end

    task automatic clear_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = {5'd31, 4'd0};
    endtask

    task automatic expect_range(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            exp_t e;
            e.note  = int'(mem[i][8:4]);
            e.addr  = i;
            e.beats = (mem[i][3:0] == 4'd0) ? 16 : int'(mem[i][3:0]);
            e.gap   = (i == first) ? -1 : 2;
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_play();
        bus.play = 1'b1;
        @(posedge clk);
        #1;
        bus.play = 1'b0;
    endtask

    task automatic wait_note_at(input int addr, input int budget, input string name);
        int k   = 0;
        bit hit = 1'b0;
        while (!hit && k < budget) begin
            @(posedge clk);
            #1;
            k++;
            hit = bus.note_valid && (int'(bus.read_address) == addr);
        end
        check(name, int'(hit), 1);
    endtask

    // Sheet end: Done and return to idle, or restart from address 0 when looping
    task automatic end_of_sheet(input string name, input int budget);
        int d0 = done_cnt;
        int k  = 0;
`ifdef LOOP_EN
        exp_t e;
        e.note  = int'(mem[0][8:4]);
        e.addr  = 0;
        e.beats = (mem[0][3:0] == 4'd0) ? 16 : int'(mem[0][3:0]);
        e.gap   = 2;
        for (int i = 0; i < DEPTH; i++) if (mem[i][8:4] == 5'd31) e.gap = 4;
        exp_q.push_back(e);
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({name, "_restart_seen"}, exp_q.size(), 0);
        check({name, "_playing"}, int'(bus.playing), 1);
        check({name, "_no_done"}, done_cnt - d0, 0);
        bus.stop = 1'b1;
        @(posedge clk);
        #1;
        bus.stop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
`else
        while (done_cnt == d0 && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({name, "_done"}, done_cnt - d0, 1);
        check({name, "_playing"}, int'(bus.playing), 0);
        check({name, "_addr"}, int'(bus.read_address), 0);
        check({name, "_note"}, int'(bus.note), 0);
        check({name, "_nv"}, int'(bus.note_valid), 0);
        check({name, "_sb_drained"}, exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_done_once"}, done_cnt - d0, 1);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1);
    end

    initial begin
        vec_t tbl [6];
        int   d0;

        tbl[0] = '{5'd3,  4'd2,  2};
        tbl[1] = '{5'd7,  4'd0,  16};
        tbl[2] = '{5'd0,  4'd3,  3};
        tbl[3] = '{5'd12, 4'd1,  1};
        tbl[4] = '{5'd30, 4'd15, 15};
        tbl[5] = '{5'd1,  4'd4,  4};

        rst      = 1'b1;
        bus.play = 1'b0;
        bus.stop = 1'b0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", int'(bus.read_address), 0);
        check("rst_note", int'(bus.note), 0);
        check("rst_nv", int'(bus.note_valid), 0);
        check("rst_playing", int'(bus.playing), 0);
        check("rst_done", int'(bus.done), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        tick_en = 1'b1;

        // Two-entry sheet: note 3 for 2 beats, then END
        clear_mem();
        mem[0]      = {5'd3, 4'd2};
        tick_period = 10;
        expect_range(0, 0);
        pulse_play();
        end_of_sheet("basic", 400);

        // Table of entries, including rest and the zero-means-16 duration
        clear_mem();
        tick_period = 3;
        for (int i = 0; i < 6; i++) begin
            exp_t e;
            mem[i]  = {tbl[i].code, tbl[i].dur};
            e.note  = int'(tbl[i].code);
            e.addr  = i;
            e.beats = tbl[i].beats;
            e.gap   = (i == 0) ? -1 : 2;
            exp_q.push_back(e);
        end
        pulse_play();
        end_of_sheet("table", 2000);

        // Stop in the middle of the note at address 4
        clear_mem();
        for (int i = 0; i < 8; i++) mem[i] = {5'(i + 1), 4'd2};
        tick_period = 4;
        expect_range(0, 4);
        pulse_play();
        wait_note_at(4, 400, "stop_reach_addr4");
        d0       = done_cnt;
        bus.stop = 1'b1;
        @(posedge clk);
        #1;
        bus.stop = 1'b0;
        check("stop_playing", int'(bus.playing), 0);
        check("stop_note", int'(bus.note), 0);
        check("stop_nv", int'(bus.note_valid), 0);
        check("stop_addr", int'(bus.read_address), 0);
        repeat (20) @(posedge clk);
        #1;
        check("stop_stays_idle", int'(bus.playing), 0);
        check("stop_no_done", done_cnt - d0, 0);
        check("stop_sb_drained", exp_q.size(), 0);

        // Play and Stop together in IDLE
        bus.play = 1'b1;
        bus.stop = 1'b1;
        @(posedge clk);
        #1;
        bus.play = 1'b0;
        bus.stop = 1'b0;
        check("playstop_playing", int'(bus.playing), 0);
        repeat (5) @(posedge clk);
        #1;
        check("playstop_idle", int'(bus.playing), 0);
        check("playstop_nv", int'(bus.note_valid), 0);

        // Play re-pulsed during playback must not restart the sheet
        clear_mem();
        for (int i = 0; i < 4; i++) mem[i] = {5'(10 + i), 4'd3};
        tick_period = 3;
        expect_range(0, 3);
        pulse_play();
        wait_note_at(1, 200, "repulse_reach_addr1");
        pulse_play();
        wait_note_at(2, 200, "repulse_reach_addr2");
        pulse_play();
        end_of_sheet("repulse", 400);

        // Full sheet with no END code: ends after address 31
        clear_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = {5'((i % 30) + 1), 4'd1};
        tick_period = 2;
        expect_range(0, DEPTH - 1);
        pulse_play();
        end_of_sheet("wrap", 3000);

        // Asynchronous reset between clock edges in the middle of a note
        clear_mem();
        mem[0]      = {5'd5, 4'd4};
        tick_period = 5;
        expect_range(0, 0);
        pulse_play();
        wait_note_at(0, 200, "arst_reach_note");
        @(posedge clk);
        #3;
        d0  = done_cnt;
        rst = 1'b1;
        #1;
        check("arst_addr", int'(bus.read_address), 0);
        check("arst_note", int'(bus.note), 0);
        check("arst_nv", int'(bus.note_valid), 0);
        check("arst_playing", int'(bus.playing), 0);
        check("arst_done", int'(bus.done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("arst_waits_idle", int'(bus.playing), 0);
        check("arst_no_done", done_cnt - d0, 0);
        expect_range(0, 0);
        pulse_play();
        end_of_sheet("arst_restart", 400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
